// File: rtl/bsr_chain_driver.sv
// Drives one boundary-scan chain: shift a pattern in, hold it, capture, shift the result out.
// done fires 2*CHAIN_LEN+APPLY_CYCLES+2 cycles after start is taken; start is dropped while busy, abort returns to idle.
module bsr_chain_driver #(
  parameter int CHAIN_LEN    = 32,
  parameter int APPLY_CYCLES = 2,
  localparam int CNT_W       = $clog2(CHAIN_LEN + APPLY_CYCLES) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result_out,
  output logic                 chain_sin,
  input  logic                 chain_sout,
  output logic                 chain_clk_en,
  output logic                 testing
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] APPLY   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] UNLOAD  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_APPLY = CNT_W'(APPLY_CYCLES - 1);

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] shreg;
  logic [CHAIN_LEN-1:0] rsr;
  logic [CHAIN_LEN-1:0] rsr_next;

  assign rsr_next = {chain_sout, rsr[CHAIN_LEN-1:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      rsr        <= '0;
      result_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= pattern_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            shreg <= shreg >> 1;
            if (cnt == LAST_BIT) begin
              cnt   <= '0;
              state <= APPLY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        APPLY: begin
          if (abort) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == LAST_APPLY) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          cnt   <= '0;
          state <= abort ? IDLE : UNLOAD;
        end
        UNLOAD: begin
          if (abort) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            rsr <= rsr_next;
            if (cnt == LAST_BIT) begin
              // Take the final sample directly so result_out is valid in the DONE cycle.
              result_out <= rsr_next;
              cnt        <= '0;
              state      <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode only registered state so no input reaches them combinationally.
  assign busy         = (state == SHIFT) || (state == APPLY) ||
                        (state == CAPTURE) || (state == UNLOAD);
  assign done         = (state == DONE);
  assign testing      = (state == SHIFT) || (state == APPLY) || (state == UNLOAD);
  assign chain_clk_en = (state == SHIFT) || (state == CAPTURE) || (state == UNLOAD);
  assign chain_sin    = (state == SHIFT) && shreg[0];

endmodule
